vga_layer_compositor: RTL and testbench
=======================================

# vga_layer_compositor

Parametrised successor to the VGA top-level pixel mux: composites `NUM_LAYERS` image layers from block RAM over a generated background, with a runtime-writable window per layer and an independent vertical scroll engine per layer (play/pause, restart, fast-forward, reverse).
- Sits between `vga_controller` (h_cnt/v_cnt/valid/syncs) and the RGB pins.
- Drives one BRAM address bus per layer.
- Aligns colour and syncs through a fixed 3-cycle pipeline.

## Interface
Parameters:
- `NUM_LAYERS`, 4, number of image layers; index 0 has the highest priority.
- `ADDR_W`, 16, BRAM address width per layer.
- `IMG_W`, 320, source image width in pixels, common to all layers.
- `SRC_H`, 240, source image height in rows; the scroll wrap modulus.
- `DIV_SLOW`, 2097152, clk cycles per scroll step at normal rate.
- `DIV_FAST`, 8192, clk cycles per scroll step while `fwd` or `bwd` is high.

Ports (all in the `clk` domain):
- `clk` in 1: pixel clock, one pixel per cycle.
- `rst` in 1: synchronous, active-low reset.
- `h_cnt`, `v_cnt` in 10 each: pixel coordinates from `vga_controller`.
- `valid` in 1: active-video flag.
- `hsync_in`, `vsync_in` in 1 each: raw syncs.
- `frame_start` in 1: one-cycle pulse at the start of each frame.
- `bg_rgb` in 12: background colour for the current pixel, sampled with `h_cnt`.
- `layer_en` in NUM_LAYERS: per-layer display enable.
- `cfg_we` in 1: configuration write strobe.
- `cfg_sel` in $clog2(NUM_LAYERS): target layer for the write.
- `cfg_field` in 2: field select; 0=x0, 1=x1, 2=y0, 3=y1.
- `cfg_data` in 10: write value.
- `play`, `restart` in NUM_LAYERS each: one-cycle command pulses.
- `fwd`, `bwd` in NUM_LAYERS each: levels.
- `pixel_addr` out NUM_LAYERS*ADDR_W: layer i occupies bits [i*ADDR_W +: ADDR_W].
- `pixel_data` in NUM_LAYERS*12: BRAM read data, 1-cycle latency.
- `rgb_out` out 12: {R,G,B}, 4 bits each.
- `hsync_out`, `vsync_out` out 1 each: syncs aligned to `rgb_out`.

## Operation
- Window registers:
  - A write sets the shadow copy of field `cfg_field` of layer `cfg_sel`.
  - Shadows copy to the active window on `frame_start`.
  - A hit requires `x0 <= h_cnt < x1`, `y0 <= v_cnt < y1`, `h_cnt-x0 < IMG_W`, `layer_en[i]` and `valid`.
  - `x0 >= x1` or `y0 >= y1` means the layer never hits.
- Scroll state per layer: PAUSED or RUN.
  - Reset state is PAUSED.
  - A `play` pulse toggles the state.
- Step generation:
  - A divider counts to `DIV_FAST` when `fwd|bwd` is high, otherwise to `DIV_SLOW`.
  - A change of `fwd|bwd` clears the divider.
  - When the divider expires in RUN, the shadow offset steps +1, or -1 if `bwd` is high.
  - If `fwd` and `bwd` are both high, `bwd` wins.
- Wrap: SRC_H-1 +1 -> 0; 0 -1 -> SRC_H-1.
- `restart`:
  - Sets the shadow offset and divider to 0.
  - Overrides a step in the same cycle.
  - Does not change PAUSED/RUN; `play` and `restart` in the same cycle both apply.
- The active offset loads from the shadow offset on `frame_start`, so there is no tearing mid-frame.
- Address: `row = (v_cnt - y0 + off) mod SRC_H`; `pixel_addr = row*IMG_W + (h_cnt - x0)`, truncated to ADDR_W. A non-hitting layer drives address 0.
- Priority: the lowest-index hitting layer selects its `pixel_data`. With no hit, `bg_rgb` is used. When `valid` is low, the output is 12'h000.

## Timing
- Cycle t: `h_cnt`/`v_cnt`/`valid`/`bg_rgb` are sampled. Cycle t+1: `pixel_addr` is registered.
- Cycle t+2: `pixel_data` is returned.
- Cycle t+3: `rgb_out` is registered. Latency is 3 cycles.
- `hsync_out` and `vsync_out` are delayed by exactly 3 cycles through the same pipeline.
- Reset values:
  - `rgb_out`=0, `pixel_addr`=0, `hsync_out`=`vsync_out`=1.
  - All windows and offsets 0, all dividers 0, all layers PAUSED.
- Reset mid-frame clears the pipeline; the first correct pixel appears 3 cycles after `rst` deasserts.
- A `cfg_we` in the same cycle as `frame_start` writes the shadow register, but the active copy takes the old shadow value; the new value is applied at the following frame.
- Step and `frame_start` in the same cycle: the active offset takes the pre-step value.

## Structure
- Package `vga_comp_pkg` holds:
  - `RGB_W=12`.
  - Field codes `CFG_X0`..`CFG_Y1`.
  - The scroll-state enum `{SC_PAUSED, SC_RUN}`.
  - The window struct (x0, x1, y0, y1).
- Sub-module `layer_scroll_ctrl` holds the state, divider, shadow and active offset for one layer. It is instantiated NUM_LAYERS times via generate.
- The hit test, address arithmetic and priority mux live in the top level.

## Test plan
- Reset, then layer 0 window (160,480,60,180) written, `frame_start`, `pixel_data[0]`=12'hF00: pixel (200,100) -> `rgb_out`=F00 and `pixel_addr[0]`=40*320+40=12840, 3 cycles later; pixel (100,100) -> `bg_rgb`.
- Layers 0 and 1 with overlapping windows, both enabled: overlap shows layer 0 data. Clearing `layer_en[0]` shows layer 1 data.
- DIV_SLOW=4 and `play` on layer 1: offset advances 1 per 4 cycles, visible only after each `frame_start`. From offset SRC_H-1, one step -> row wraps to 0.
- `bwd` held from offset 0 -> next step gives SRC_H-1, at DIV_FAST rate. `restart` together with a step -> offset 0.
- `valid` low -> `rgb_out`=000. The sync pulse pattern appears on the outputs shifted by exactly 3 cycles.
- `rst` low mid-frame for 1 cycle -> all outputs return to their reset values next edge, and the layer goes back to PAUSED.

Source files
------------

// File: rtl/vga_comp_pkg.sv
// Shared types and constants for the layered VGA compositor.
package vga_comp_pkg;

  localparam int RGB_W = 12;

  localparam logic [1:0] CFG_X0 = 2'd0;
  localparam logic [1:0] CFG_X1 = 2'd1;
  localparam logic [1:0] CFG_Y0 = 2'd2;
  localparam logic [1:0] CFG_Y1 = 2'd3;

  typedef enum logic {SC_PAUSED, SC_RUN} scroll_state_t;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
  } window_t;

endpackage

// File: rtl/layer_scroll_ctrl.sv
// Per-layer vertical scroll engine: play/pause state, step divider,
// shadow offset and frame-synchronous active offset.
module layer_scroll_ctrl
  import vga_comp_pkg::*;
#(
  parameter int SRC_H    = 240,
  parameter int DIV_SLOW = 2097152,
  parameter int DIV_FAST = 8192
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     play,
  input  logic                     restart,
  input  logic                     fwd,
  input  logic                     bwd,
  output logic [$clog2(SRC_H)-1:0] active_off
);

  localparam int OFF_W   = $clog2(SRC_H);
  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int DIV_W   = $clog2(DIV_MAX + 1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(SRC_H - 1);

  scroll_state_t    state, state_n;
  logic [DIV_W-1:0] div, div_n, lim_m1;
  logic [OFF_W-1:0] shd_off, shd_n;
  logic             fast, fast_q, expire;

  always_comb begin
    fast    = fwd | bwd;
    lim_m1  = fast ? DIV_W'(DIV_FAST - 1) : DIV_W'(DIV_SLOW - 1);
    expire  = (state == SC_RUN) && (fast == fast_q) && (div >= lim_m1);
    state_n = state;
    div_n   = div;
    shd_n   = shd_off;
    if (play)
      state_n = (state == SC_RUN) ? SC_PAUSED : SC_RUN;
    // restart dominates a rate change and any step due this cycle
    if (restart) begin
      div_n = '0;
      shd_n = '0;
    end else if (fast != fast_q) begin
      div_n = '0;
    end else if (expire) begin
      div_n = '0;
      if (bwd)
        shd_n = (shd_off == '0) ? OFF_LAST : shd_off - OFF_W'(1);
      else
        shd_n = (shd_off == OFF_LAST) ? '0 : shd_off + OFF_W'(1);
    end else if (state == SC_RUN) begin
      div_n = div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= SC_PAUSED;
      div        <= '0;
      shd_off    <= '0;
      active_off <= '0;
      fast_q     <= 1'b0;
    end else begin
      state   <= state_n;
      div     <= div_n;
      shd_off <= shd_n;
      fast_q  <= fast;
      if (frame_start)
        active_off <= shd_off;
    end
  end

endmodule

// File: rtl/vga_layer_compositor.sv
// Composites NUM_LAYERS windowed, scrollable BRAM image layers over a
// background colour with a fixed 3-cycle colour/sync pipeline.
module vga_layer_compositor
  import vga_comp_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int ADDR_W     = 16,
  parameter int IMG_W      = 320,
  parameter int SRC_H      = 240,
  parameter int DIV_SLOW   = 2097152,
  parameter int DIV_FAST   = 8192
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    h_cnt,
  input  logic [9:0]                    v_cnt,
  input  logic                          valid,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          frame_start,
  input  logic [RGB_W-1:0]              bg_rgb,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_LAYERS)-1:0] cfg_sel,
  input  logic [1:0]                    cfg_field,
  input  logic [9:0]                    cfg_data,
  input  logic [NUM_LAYERS-1:0]         play,
  input  logic [NUM_LAYERS-1:0]         restart,
  input  logic [NUM_LAYERS-1:0]         fwd,
  input  logic [NUM_LAYERS-1:0]         bwd,
  output logic [NUM_LAYERS*ADDR_W-1:0]  pixel_addr,
  input  logic [NUM_LAYERS*RGB_W-1:0]   pixel_data,
  output logic [RGB_W-1:0]              rgb_out,
  output logic                          hsync_out,
  output logic                          vsync_out
);

  localparam int OFF_W = $clog2(SRC_H);
  localparam int SEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  window_t                      shd_win [NUM_LAYERS];
  window_t                      act_win [NUM_LAYERS];
  logic [OFF_W-1:0]             act_off [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]        hit;
  logic [NUM_LAYERS*ADDR_W-1:0] addr_d;
  logic                         sel_any, s1_any, s2_any;
  logic [SEL_W-1:0]             sel_idx, s1_sel, s2_sel;
  logic                         s1_valid, s2_valid;
  logic [RGB_W-1:0]             s1_bg, s2_bg;
  logic [2:0]                   hs_pipe, vs_pipe;

  // The active copy latches the pre-write shadow when a write and
  // frame_start coincide, so the new value lands one frame later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        shd_win[i] <= '0;
        act_win[i] <= '0;
      end
    end else begin
      if (frame_start)
        for (int unsigned i = 0; i < NUM_LAYERS; i++)
          act_win[i] <= shd_win[i];
      if (cfg_we) begin
        case (cfg_field)
          CFG_X0:  shd_win[cfg_sel].x0 <= cfg_data;
          CFG_X1:  shd_win[cfg_sel].x1 <= cfg_data;
          CFG_Y0:  shd_win[cfg_sel].y0 <= cfg_data;
          default: shd_win[cfg_sel].y1 <= cfg_data;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    logic [9:0]  dx, dy;
    logic [31:0] row;

    layer_scroll_ctrl #(
      .SRC_H   (SRC_H),
      .DIV_SLOW(DIV_SLOW),
      .DIV_FAST(DIV_FAST)
    ) u_scroll (
      .clk        (clk),
      .rst        (rst),
      .frame_start(frame_start),
      .play       (play[g]),
      .restart    (restart[g]),
      .fwd        (fwd[g]),
      .bwd        (bwd[g]),
      .active_off (act_off[g])
    );

    assign dx     = h_cnt - act_win[g].x0;
    assign dy     = v_cnt - act_win[g].y0;
    assign hit[g] = valid && layer_en[g]
                 && (h_cnt >= act_win[g].x0) && (h_cnt < act_win[g].x1)
                 && (v_cnt >= act_win[g].y0) && (v_cnt < act_win[g].y1)
                 && (32'(dx) < 32'(IMG_W));
    assign row    = (32'(dy) + 32'(act_off[g])) % 32'(SRC_H);
    assign addr_d[g*ADDR_W +: ADDR_W] =
      hit[g] ? ADDR_W'(row * 32'(IMG_W) + 32'(dx)) : '0;
  end

  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (hit[i] && !sel_any) begin
        sel_any = 1'b1;
        sel_idx = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pixel_addr <= '0;
      s1_any     <= 1'b0;
      s1_sel     <= '0;
      s1_valid   <= 1'b0;
      s1_bg      <= '0;
      s2_any     <= 1'b0;
      s2_sel     <= '0;
      s2_valid   <= 1'b0;
      s2_bg      <= '0;
      rgb_out    <= '0;
      hs_pipe    <= '1;
      vs_pipe    <= '1;
    end else begin
      pixel_addr <= addr_d;
      s1_any     <= sel_any;
      s1_sel     <= sel_idx;
      s1_valid   <= valid;
      s1_bg      <= bg_rgb;
      s2_any     <= s1_any;
      s2_sel     <= s1_sel;
      s2_valid   <= s1_valid;
      s2_bg      <= s1_bg;
      if (!s2_valid)
        rgb_out <= '0;
      else if (s2_any)
        rgb_out <= pixel_data[s2_sel*RGB_W +: RGB_W];
      else
        rgb_out <= s2_bg;
      hs_pipe <= {hs_pipe[1:0], hsync_in};
      vs_pipe <= {vs_pipe[1:0], vsync_in};
    end
  end

  assign hsync_out = hs_pipe[2];
  assign vsync_out = vs_pipe[2];

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Randomised self-checking bench for vga_layer_compositor against a
// behavioural compositing/scroll model with a synchronous BRAM stand-in.
module tb_vga_layer_compositor;

  localparam int NL = 4;
  localparam int AW = 16;
  localparam int IW = 320;
  localparam int SH = 240;
  localparam int DS = 4;
  localparam int DF = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [9:0]    h_cnt = '0, v_cnt = '0;
  logic          valid = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic          frame_start = 1'b0;
  logic [11:0]   bg_rgb = '0;
  logic [NL-1:0] layer_en = '0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_sel = '0, cfg_field = '0;
  logic [9:0]    cfg_data = '0;
  logic [NL-1:0] play = '0, restart = '0, fwd = '0, bwd = '0;
  logic [NL*AW-1:0] pixel_addr;
  logic [NL*12-1:0] pixel_data = '0;
  logic [11:0]   rgb_out;
  logic          hsync_out, vsync_out;

  always #5 clk = ~clk;

  vga_layer_compositor #(
    .NUM_LAYERS(NL), .ADDR_W(AW), .IMG_W(IW), .SRC_H(SH),
    .DIV_SLOW(DS), .DIV_FAST(DF)
  ) dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
    .bg_rgb(bg_rgb), .layer_en(layer_en), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_field(cfg_field), .cfg_data(cfg_data), .play(play), .restart(restart),
    .fwd(fwd), .bwd(bwd), .pixel_addr(pixel_addr), .pixel_data(pixel_data),
    .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  // Image content: a per-layer hash of the address, one cycle of read latency.
  function automatic logic [11:0] bram(int layer, logic [AW-1:0] a);
    return 12'((int'(a) * 37) ^ (layer * 'h5A3));
  endfunction

  always @(posedge clk)
    for (int i = 0; i < NL; i++)
      pixel_data[i*12 +: 12] <= bram(i, pixel_addr[i*AW +: AW]);

  typedef struct {
    logic [NL*AW-1:0] addr;
    int               sel;
    bit               vld;
    logic [11:0]      bg;
    logic             hs, vs;
  } rec_t;

  int   win_sh [NL][4];
  int   win_ac [NL][4];
  bit   run    [NL];
  int   divc   [NL];
  bit   fprev  [NL];
  int   off_sh [NL];
  int   off_ac [NL];
  rec_t r0, r1, r2;
  logic [NL*AW-1:0] exp_addr;
  logic [11:0]      exp_rgb;
  logic             exp_hs, exp_vs;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic rec_t reset_rec();
    rec_t r;
    r.addr = '0; r.sel = -1; r.vld = 0; r.bg = '0; r.hs = 1'b1; r.vs = 1'b1;
    return r;
  endfunction

  // Advances the model by one clock edge using the inputs the DUT sees.
  task automatic model_edge();
    rec_t n;
    int h, v, x0, x1, y0, y1;
    bit f;
    if (!rst) begin
      for (int i = 0; i < NL; i++) begin
        for (int k = 0; k < 4; k++) begin win_sh[i][k] = 0; win_ac[i][k] = 0; end
        run[i] = 0; divc[i] = 0; fprev[i] = 0; off_sh[i] = 0; off_ac[i] = 0;
      end
      r0 = reset_rec(); r1 = r0; r2 = r0;
    end else begin
      n = reset_rec();
      n.vld = valid; n.bg = bg_rgb; n.hs = hsync_in; n.vs = vsync_in;
      h = int'(h_cnt); v = int'(v_cnt);
      for (int i = 0; i < NL; i++) begin
        x0 = win_ac[i][0]; x1 = win_ac[i][1]; y0 = win_ac[i][2]; y1 = win_ac[i][3];
        if (valid && layer_en[i] && h >= x0 && h < x1 && v >= y0 && v < y1 && h - x0 < IW) begin
          n.addr[i*AW +: AW] = AW'(((v - y0 + off_ac[i]) % SH) * IW + (h - x0));
          if (n.sel < 0) n.sel = i;
        end
      end
      r2 = r1; r1 = r0; r0 = n;
      if (frame_start)
        for (int i = 0; i < NL; i++)
          for (int k = 0; k < 4; k++) win_ac[i][k] = win_sh[i][k];
      if (cfg_we) win_sh[cfg_sel][cfg_field] = int'(cfg_data);
      for (int i = 0; i < NL; i++) begin
        f = fwd[i] | bwd[i];
        if (frame_start) off_ac[i] = off_sh[i];
        if (restart[i]) begin
          off_sh[i] = 0; divc[i] = 0;
        end else if (f != fprev[i]) begin
          divc[i] = 0;
        end else if (run[i]) begin
          divc[i]++;
          if (divc[i] == (f ? DF : DS)) begin
            divc[i] = 0;
            off_sh[i] = bwd[i] ? (off_sh[i] + SH - 1) % SH : (off_sh[i] + 1) % SH;
          end
        end
        if (play[i]) run[i] = !run[i];
        fprev[i] = f;
      end
    end
    exp_addr = r0.addr;
    exp_hs   = r2.hs;
    exp_vs   = r2.vs;
    if (!r2.vld)        exp_rgb = 12'h000;
    else if (r2.sel < 0) exp_rgb = r2.bg;
    else                 exp_rgb = bram(r2.sel, r2.addr[r2.sel*AW +: AW]);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    frame_start = 1'b0; cfg_we = 1'b0; play = '0; restart = '0;
  endtask

  task automatic cfg_write(int l, int f, int d);
    cfg_we = 1'b1; cfg_sel = 2'(l); cfg_field = 2'(f); cfg_data = 10'(d);
    cycle();
  endtask

  task automatic rand_px(int xlo, int xhi, int ylo, int yhi);
    h_cnt    = 10'($urandom_range(xhi, xlo));
    v_cnt    = 10'($urandom_range(yhi, ylo));
    valid    = 1'b1;
    bg_rgb   = 12'($urandom);
    hsync_in = 1'($urandom);
    vsync_in = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cycle(); cycle();
    n_checks++; if (rgb_out !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h expected 000", rgb_out); end
    n_checks++; if (pixel_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", pixel_addr); end
    n_checks++; if (hsync_out !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b expected 1", hsync_out); end
    n_checks++; if (vsync_out !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b expected 1", vsync_out); end
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_single_layer();
    logic [11:0] bg_b;
    cfg_write(0, 0, 160); cfg_write(0, 1, 480); cfg_write(0, 2, 60); cfg_write(0, 3, 180);
    layer_en = 4'b0001; frame_start = 1'b1; cycle();
    h_cnt = 10'd200; v_cnt = 10'd100; valid = 1'b1; bg_rgb = 12'h5A5;
    cycle();
    n_checks++; if (pixel_addr[AW-1:0] !== 16'd12840) begin n_fail++; $display("FAIL single_addr: got %0d expected 12840", pixel_addr[AW-1:0]); end
    h_cnt = 10'd100; bg_b = 12'($urandom); bg_rgb = bg_b;
    cycle(); cycle();
    n_checks++; if (rgb_out !== bram(0, 16'd12840)) begin n_fail++; $display("FAIL single_rgb: got %h expected %h", rgb_out, bram(0, 16'd12840)); end
    cycle();
    n_checks++; if (rgb_out !== bg_b) begin n_fail++; $display("FAIL single_bg: got %h expected %h", rgb_out, bg_b); end
    for (int c = 0; c < 40; c++) begin
      rand_px(120, 520, 40, 200);
      cycle();
      n_checks++; if (rgb_out !== exp_rgb) begin n_fail++; $display("FAIL single_rnd_rgb: got %h expected %h", rgb_out, exp_rgb); end
      n_checks++; if (pixel_addr !== exp_addr) begin n_fail++; $display("FAIL single_rnd_addr: got %h expected %h", pixel_addr, exp_addr); end
    end
  endtask

  task automatic test_priority();
    cfg_write(1, 0, 200); cfg_write(1, 1, 600); cfg_write(1, 2, 80); cfg_write(1, 3, 300);
    cfg_write(2, 0, 300); cfg_write(2, 1, 300); cfg_write(2, 2, 0);  cfg_write(2, 3, 400);
    cfg_write(3, 0, 0);   cfg_write(3, 1, 600); cfg_write(3, 2, 200); cfg_write(3, 3, 100);
    layer_en = 4'b1111; frame_start = 1'b1; cycle();
    for (int c = 0; c < 120; c++) begin
      if (c == 60) layer_en = 4'b1110;
      rand_px(140, 600, 40, 320);
      cycle();
      n_checks++; if (rgb_out !== exp_rgb) begin n_fail++; $display("FAIL prio_rgb: got %h expected %h", rgb_out, exp_rgb); end
      n_checks++; if (pixel_addr !== exp_addr) begin n_fail++; $display("FAIL prio_addr: got %h expected %h", pixel_addr, exp_addr); end
    end
  endtask

  task automatic test_scroll();
    layer_en = 4'b0010; play = 4'b0010; cycle();
    for (int c = 0; c < 1100; c++) begin
      frame_start = (c % 37 == 0);
      rand_px(200, 520, 80, 300);
      cycle();
      n_checks++; if (rgb_out !== exp_rgb) begin n_fail++; $display("FAIL scroll_rgb: got %h expected %h", rgb_out, exp_rgb); end
      n_checks++; if (pixel_addr !== exp_addr) begin n_fail++; $display("FAIL scroll_addr: got %h expected %h", pixel_addr, exp_addr); end
    end
  endtask

  task automatic test_bwd_restart();
    if (!run[1]) begin play = 4'b0010; cycle(); end
    h_cnt = 10'd0; v_cnt = 10'd0;
    restart = 4'b0010; bwd = 4'b0010; fwd = '0; cycle();
    cycle(); cycle();
    frame_start = 1'b1; cycle();
    h_cnt = 10'd200; v_cnt = 10'd80; valid = 1'b1;
    cycle();
    n_checks++; if (pixel_addr[AW +: AW] !== 16'(239 * IW)) begin n_fail++; $display("FAIL bwd_wrap: got %0d expected %0d", pixel_addr[AW +: AW], 16'(239 * IW)); end
    for (int c = 0; c < 300; c++) begin
      frame_start = (c % 7 == 0);
      restart     = ($urandom_range(19, 0) == 0) ? 4'b0010 : 4'b0000;
      if ($urandom_range(49, 0) == 0) fwd[1] = ~fwd[1];
      if (c == 200) bwd[1] = 1'b0;
      rand_px(200, 520, 80, 300);
      cycle();
      n_checks++; if (rgb_out !== exp_rgb) begin n_fail++; $display("FAIL bwd_rgb: got %h expected %h", rgb_out, exp_rgb); end
      n_checks++; if (pixel_addr !== exp_addr) begin n_fail++; $display("FAIL bwd_addr: got %h expected %h", pixel_addr, exp_addr); end
    end
  endtask

  task automatic test_valid_sync();
    for (int c = 0; c < 200; c++) begin
      rand_px(0, 700, 0, 500);
      valid    = 1'($urandom);
      layer_en = 4'($urandom);
      cycle();
      n_checks++; if (rgb_out !== exp_rgb) begin n_fail++; $display("FAIL vs_rgb: got %h expected %h", rgb_out, exp_rgb); end
      n_checks++; if (hsync_out !== exp_hs) begin n_fail++; $display("FAIL vs_hsync: got %b expected %b", hsync_out, exp_hs); end
      n_checks++; if (vsync_out !== exp_vs) begin n_fail++; $display("FAIL vs_vsync: got %b expected %b", vsync_out, exp_vs); end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 400; c++) begin
      frame_start = ($urandom_range(5, 0) == 0);
      cfg_we      = 1'($urandom);
      cfg_sel     = 2'($urandom);
      cfg_field   = 2'($urandom);
      cfg_data    = 10'($urandom_range(640, 0));
      play        = ($urandom_range(9, 0) == 0) ? 4'($urandom) : 4'b0000;
      restart     = ($urandom_range(9, 0) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(15, 0) == 0) fwd = 4'($urandom);
      if ($urandom_range(15, 0) == 0) bwd = 4'($urandom);
      layer_en    = 4'($urandom);
      rand_px(0, 660, 0, 500);
      cycle();
      n_checks++; if (rgb_out !== exp_rgb) begin n_fail++; $display("FAIL b2b_rgb: got %h expected %h", rgb_out, exp_rgb); end
      n_checks++; if (pixel_addr !== exp_addr) begin n_fail++; $display("FAIL b2b_addr: got %h expected %h", pixel_addr, exp_addr); end
      n_checks++; if ({hsync_out, vsync_out} !== {exp_hs, exp_vs}) begin n_fail++; $display("FAIL b2b_sync: got %b%b expected %b%b", hsync_out, vsync_out, exp_hs, exp_vs); end
    end
  endtask

  task automatic test_reset_mid();
    fwd = '0; bwd = '0; layer_en = 4'b0001;
    if (!run[0]) begin play = 4'b0001; cycle(); end
    rand_px(160, 400, 60, 170);
    rst = 1'b0; cycle();
    n_checks++; if (rgb_out !== 12'h000) begin n_fail++; $display("FAIL mid_rst_rgb: got %h expected 000", rgb_out); end
    n_checks++; if (pixel_addr !== '0) begin n_fail++; $display("FAIL mid_rst_addr: got %h expected 0", pixel_addr); end
    n_checks++; if ({hsync_out, vsync_out} !== 2'b11) begin n_fail++; $display("FAIL mid_rst_sync: got %b%b expected 11", hsync_out, vsync_out); end
    rst = 1'b1;
    cfg_write(0, 0, 160); cfg_write(0, 1, 480); cfg_write(0, 2, 60); cfg_write(0, 3, 180);
    for (int c = 0; c < 30; c++) begin
      frame_start = (c % 5 == 0);
      rand_px(160, 479, 60, 179);
      cycle();
      n_checks++; if (pixel_addr !== exp_addr) begin n_fail++; $display("FAIL mid_rst_run_addr: got %h expected %h", pixel_addr, exp_addr); end
    end
    h_cnt = 10'd200; v_cnt = 10'd100; valid = 1'b1;
    cycle();
    n_checks++; if (pixel_addr[AW-1:0] !== 16'd12840) begin n_fail++; $display("FAIL mid_rst_paused: got %0d expected 12840", pixel_addr[AW-1:0]); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_single_layer();
    test_priority();
    test_scroll();
    test_bwd_restart();
    test_valid_sync();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
